psma_mac_acc: RTL and testbench
===============================

# psma_mac_acc

Precision-scalable, sum-together (output-shared) multiply-accumulate unit for the PSMA array. It is the sequential, parametrised successor of the 4b×4b L1 multiplier. Each accepted beat forms the sum of 1, 2 or 4 unsigned sub-word products from a WIDTH-bit activation/weight pair, selected by precision. A two-stage pipeline accumulates that sum over a beat group terminated by `in_last`, and the group result is presented on a held, back-pressured output.

## Interface
- `WIDTH`, 8: operand width; power of two, ≥ 8, so every lane is ≥ 2 bits.
- `ACC_WIDTH`, 24: accumulator/result width; must be ≥ 2·WIDTH.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low. One clock only.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_a`  in  WIDTH  activation.
- `in_w`  in  WIDTH  weight.
- `in_prec`  in  2  precision code.
  - 00: one WIDTH×WIDTH product.
  - 01: two (WIDTH/2)² products.
  - 10: four (WIDTH/4)² products.
  - 11: reserved, treated as 00.
- `in_last`  in  1  final beat of the current group.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_acc`  out  ACC_WIDTH  group result.
- `out_ovf`  out  1  group saturated.

## Operation
- Lanes: lane i of `a` (bits [i·L+L−1 : i·L], L = WIDTH/N) multiplies lane i of `w` only. Beat sum = Σ products, zero-extended to 2·WIDTH bits. All arithmetic is unsigned.
- Precision is sampled on the first beat of a group and held until that group's last beat. `in_prec` on later beats is ignored.
- FSM (tracks the input side):
  - IDLE: no group open.
  - An accepted beat with `in_last`=0 opens a group: → ACCUM.
  - An accepted beat with `in_last`=1 in IDLE is a one-beat group: stay in IDLE.
  - ACCUM: an accepted beat with `in_last`=1 → IDLE.
- Stage 1 register holds the beat sum plus `first`/`last` flags.
- Stage 2 accumulator update:
  - If `first`: acc = sum.
  - Otherwise: acc = acc + sum.
  - Saturation: if the ACC_WIDTH-bit add carries out, acc = all-ones and the sticky ovf bit is set. Sticky ovf clears on the `first` beat.
- When a `last` beat reaches stage 2, the accumulated value and ovf are loaded into the output register and `out_valid` is set.
- Advance: adv = !out_valid || out_ready. `in_ready` = adv. Stage 1, stage 2 and the FSM update only when adv=1. The whole pipe freezes while a result is held unconsumed.
- Simultaneous events:
  - Output consumed in the same cycle a new result is loaded: the new result replaces it and `out_valid` stays 1.
  - A bubble (stage 1 empty) leaves acc unchanged.
- Reset: all outputs and state go to zero or IDLE asynchronously.
  - `in_ready`=1 after reset because `out_valid`=0.
  - Reset mid-group discards the partial accumulation. The next accepted beat starts a new group.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_acc`=0, `out_ovf`=0.
- Latency: last beat accepted at edge t → stage 1 at t → acc/output loaded at edge t+1 → `out_valid`=1 in the cycle after t+1 (2 cycles from acceptance, no stall).
- Throughput: one beat per cycle while `out_ready`=1 or no result is held.
- `out_acc`/`out_ovf` are stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_valid`/`out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- WIDTH=8, prec=00, a=0xFF, w=0xFF, last=1 → `out_acc`=0xFE01 two cycles later, `out_ovf`=0.
- prec=01, a=0x32, w=0x54, last=1 → 2·4 + 3·5 = 23. Then prec=10, a=0xE4, w=0xFF, last=1 → 3·3 + 2·3 + 1·3 + 0 = 18 on the next result.
- Group of 3 beats, with prec changed to 10 on beat 2: beat 1 prec=01, a=0x11, w=0x11; beats 2–3 a=0x11, w=0x11 → 2+2+2 = 6 (first-beat precision used).
- ACC_WIDTH=16, two beats of prec=00, 0xFF×0xFF → `out_acc`=0xFFFF, `out_ovf`=1. The next single-beat group 0x02×0x03 → 6, `out_ovf`=0.
- Hold `out_ready`=0 with a result pending → `in_ready`=0, result stable. Stream beats, release `out_ready` → no beat lost or duplicated; results match the golden model.
- Assert `rst_n`=0 mid-group → all outputs 0 immediately. After release, a single beat 0x05×0x07 (prec=00) → 35.

Source files
------------

// File: rtl/psma_mac_acc_if.sv
// Beat/result handshake bundle for psma_mac_acc: a valid/ready beat channel
// in and a held, back-pressured result channel out.
interface psma_mac_acc_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_w;
  logic [1:0]           in_prec;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 out_ovf;

  modport master (
    output in_valid, in_a, in_w, in_prec, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_w, in_prec, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/psma_mac_acc.sv
// Precision-scalable sum-together MAC: per-beat sum of 1/2/4 unsigned lane
// products, accumulated over a beat group in a two-stage, stall-on-hold pipe.
module psma_mac_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  psma_mac_acc_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int HL = WIDTH / 2;
  localparam int QL = WIDTH / 4;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e               state_q, state_d;
  logic [1:0]           prec_q, prec_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [PW-1:0]        s1_sum_q, s1_sum_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 adv;
  logic                 accept;
  logic [1:0]           eff_prec;
  logic [PW-1:0]        sum_full, sum_half, sum_quar, beat_sum;
  logic [ACC_WIDTH:0]   add_ext;

  // The whole pipe freezes while a result sits unconsumed.
  assign adv      = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && adv;
  assign eff_prec = (state_q == IDLE) ? bus.in_prec : prec_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum_full = PW'(bus.in_a) * PW'(bus.in_w);
    sum_half = '0;
    sum_quar = '0;
    for (int i = 0; i < 2; i++) begin
      sum_half = sum_half + PW'(bus.in_a[i*HL +: HL]) * PW'(bus.in_w[i*HL +: HL]);
    end
    for (int i = 0; i < 4; i++) begin
      sum_quar = sum_quar + PW'(bus.in_a[i*QL +: QL]) * PW'(bus.in_w[i*QL +: QL]);
    end
    unique case (eff_prec)
      2'b01:   beat_sum = sum_half;
      2'b10:   beat_sum = sum_quar;
      default: beat_sum = sum_full;
    endcase
  end

  // Input-side FSM and stage 1. A bubble enters stage 1 when nothing is accepted.
  always_comb begin
    state_d    = state_q;
    prec_d     = prec_q;
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    if (adv) begin
      s1_valid_d = accept;
      s1_sum_d   = beat_sum;
      s1_first_d = (state_q == IDLE);
      s1_last_d  = bus.in_last;
      if (accept) begin
        if (state_q == IDLE) prec_d = bus.in_prec;
        state_d = bus.in_last ? IDLE : ACCUM;
      end
    end
  end

  // Stage 2: saturating accumulate, then load the output register on `last`.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    add_ext     = {1'b0, acc_q} + (ACC_WIDTH+1)'(s1_sum_q);
    if (bus.out_ready) out_valid_d = 1'b0;
    if (adv && s1_valid_q) begin
      if (s1_first_q) begin
        acc_d = ACC_WIDTH'(s1_sum_q);
        ovf_d = 1'b0;
      end else if (add_ext[ACC_WIDTH]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = add_ext[ACC_WIDTH-1:0];
      end
      if (s1_last_q) begin
        out_acc_d   = acc_d;
        out_ovf_d   = ovf_d;
        out_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; all of them, datapath included, are reset because a
  // reset mid-group must discard the partial accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prec_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prec_q      <= prec_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_psma_mac_acc.sv
// Bench for psma_mac_acc: directed vectors on a 24-bit and a 16-bit
// accumulator instance, checked against a lane-arithmetic group model.
module tb_psma_mac_acc;
  localparam int W = 8;

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_results[2];

  exp_t   exp_q[2][$];
  bit     m_open[2];
  int     m_prec[2];
  longint m_acc[2];
  bit     m_ovf[2];

  psma_mac_acc_if #(.WIDTH(W), .ACC_WIDTH(24)) bus0 ();
  psma_mac_acc_if #(.WIDTH(W), .ACC_WIDTH(16)) bus1 ();

  psma_mac_acc #(.WIDTH(W), .ACC_WIDTH(24)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  psma_mac_acc #(.WIDTH(W), .ACC_WIDTH(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Sum of lane products, written straight from the lane definition.
  function automatic longint beat_sum(input longint a, input longint w, input int prec);
    int     n;
    int     l;
    longint m;
    longint s;
    n = (prec == 1) ? 2 : (prec == 2) ? 4 : 1;
    l = W / n;
    m = longint'(1) << l;
    s = 0;
    for (int i = 0; i < n; i++) s += ((a >> (i * l)) % m) * ((w >> (i * l)) % m);
    return s;
  endfunction

  function automatic int acc_w(input int d);
    return (d == 0) ? 24 : 16;
  endfunction

  task automatic model_beat(input int d, input longint a, input longint w, input int prec, input bit last);
    longint lim;
    exp_t   e;
    lim = (longint'(1) << acc_w(d)) - 1;
    if (!m_open[d]) begin
      m_prec[d] = prec;
      m_acc[d]  = 0;
      m_ovf[d]  = 1'b0;
    end
    m_acc[d] += beat_sum(a, w, m_prec[d]);
    if (m_acc[d] > lim) begin
      m_acc[d] = lim;
      m_ovf[d] = 1'b1;
    end
    if (last) begin
      e.acc = m_acc[d];
      e.ovf = m_ovf[d];
      exp_q[d].push_back(e);
    end
    m_open[d] = !last;
  endtask

  // Model sees every handshake; reset throws away open groups and pending results.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_open[d] = 1'b0;
        exp_q[d].delete();
      end
    end else begin
      if (bus0.in_valid && bus0.in_ready)
        model_beat(0, longint'(bus0.in_a), longint'(bus0.in_w), int'(bus0.in_prec), bus0.in_last);
      if (bus1.in_valid && bus1.in_ready)
        model_beat(1, longint'(bus1.in_a), longint'(bus1.in_w), int'(bus1.in_prec), bus1.in_last);
    end
  end

  function automatic bit ready_of(input int d);
    return (d == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction
  function automatic bit valid_of(input int d);
    return (d == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction
  function automatic bit oready_of(input int d);
    return (d == 0) ? bus0.out_ready : bus1.out_ready;
  endfunction
  function automatic logic [63:0] acc_of(input int d);
    return (d == 0) ? 64'(bus0.out_acc) : 64'(bus1.out_acc);
  endfunction
  function automatic bit ovf_of(input int d);
    return (d == 0) ? bus0.out_ovf : bus1.out_ovf;
  endfunction

  task automatic cmp(input int d);
    check($sformatf("in_ready%0d", d), 64'(ready_of(d)), 64'(!valid_of(d) || oready_of(d)));
    if (valid_of(d)) begin
      check($sformatf("result_expected%0d", d), 64'(exp_q[d].size() != 0), 64'd1);
      if (exp_q[d].size() != 0) begin
        check($sformatf("acc%0d", d), acc_of(d), 64'(exp_q[d][0].acc));
        check($sformatf("ovf%0d", d), 64'(ovf_of(d)), 64'(exp_q[d][0].ovf));
        if (oready_of(d)) begin
          void'(exp_q[d].pop_front());
          n_results[d]++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp(0);
      cmp(1);
    end
  end

  task automatic drive(input int d, input bit v, input logic [7:0] a, input logic [7:0] w,
                       input logic [1:0] p, input bit l);
    if (d == 0) begin
      bus0.in_valid = v; bus0.in_a = a; bus0.in_w = w; bus0.in_prec = p; bus0.in_last = l;
    end else begin
      bus1.in_valid = v; bus1.in_a = a; bus1.in_w = w; bus1.in_prec = p; bus1.in_last = l;
    end
  endtask

  task automatic set_ready(input int d, input bit r);
    if (d == 0) bus0.out_ready = r;
    else        bus1.out_ready = r;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the handshake completes (bounded).
  task automatic send(input int d, input logic [7:0] a, input logic [7:0] w,
                      input logic [1:0] p, input bit l);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    drive(d, 1'b1, a, w, p, l);
    while (!done && n < 50) begin
      @(negedge clk);
      done = ready_of(d);
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check($sformatf("send_timeout%0d", d), 64'(done), 64'd1);
    drive(d, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
  endtask

  task automatic expect_result(input int d, input string nm, input logic [63:0] e_acc,
                               input bit e_ovf, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_of(d) && n < 20);
    lat = n;
    check({nm, "_valid"}, 64'(valid_of(d)), 64'd1);
    if (valid_of(d)) begin
      check({nm, "_acc"}, acc_of(d), e_acc);
      check({nm, "_ovf"}, 64'(ovf_of(d)), 64'(e_ovf));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    n_results[0] = 0;
    n_results[1] = 0;
    drive(0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    set_ready(0, 1'b1);
    set_ready(1, 1'b1);

    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_in_ready%0d", d), 64'(ready_of(d)), 64'd1);
      check($sformatf("rst_out_valid%0d", d), 64'(valid_of(d)), 64'd0);
      check($sformatf("rst_out_acc%0d", d), acc_of(d), 64'd0);
      check($sformatf("rst_out_ovf%0d", d), 64'(ovf_of(d)), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);

    // Full-width product and two-cycle latency.
    send(0, 8'hFF, 8'hFF, 2'b00, 1'b1);
    expect_result(0, "full_ff", 64'hFE01, 1'b0, lat);
    check("latency", 64'(lat), 64'd2);

    // Back-to-back single-beat groups at half and quarter precision.
    send(0, 8'h32, 8'h54, 2'b01, 1'b1);
    send(0, 8'hE4, 8'hFF, 2'b10, 1'b1);
    expect_result(0, "half_23", 64'd23, 1'b0, lat);
    expect_result(0, "quar_18", 64'd18, 1'b0, lat);

    // Precision sampled on the first beat only.
    send(0, 8'h11, 8'h11, 2'b01, 1'b0);
    send(0, 8'h11, 8'h11, 2'b10, 1'b0);
    send(0, 8'h11, 8'h11, 2'b10, 1'b1);
    expect_result(0, "grp3_6", 64'd6, 1'b0, lat);
    send(0, 8'h11, 8'h11, 2'b00, 1'b0);
    send(0, 8'h11, 8'h11, 2'b10, 1'b1);
    expect_result(0, "prec_hold", 64'd578, 1'b0, lat);

    // Reserved code behaves as full width.
    send(0, 8'h12, 8'h34, 2'b11, 1'b1);
    expect_result(0, "prec_rsvd", 64'd936, 1'b0, lat);

    // Back-pressure: held result freezes the pipe.
    set_ready(0, 1'b0);
    send(0, 8'h03, 8'h04, 2'b00, 1'b1);
    tick(3);
    @(negedge clk);
    check("hold_in_ready", 64'(bus0.in_ready), 64'd0);
    check("hold_valid", 64'(bus0.out_valid), 64'd1);
    check("hold_acc", 64'(bus0.out_acc), 64'd12);
    @(posedge clk);
    #1;
    fork
      begin
        send(0, 8'h02, 8'h03, 2'b00, 1'b0);
        send(0, 8'h04, 8'h05, 2'b00, 1'b1);
        send(0, 8'h21, 8'h13, 2'b01, 1'b1);
        send(0, 8'hFF, 8'hFF, 2'b10, 1'b1);
        send(0, 8'h0A, 8'h0B, 2'b00, 1'b1);
      end
      begin
        tick(4);
        set_ready(0, 1'b1);
        tick(1);
        set_ready(0, 1'b0);
        tick(2);
        set_ready(0, 1'b1);
      end
    join
    tick(6);
    check("stream_drain0", 64'(exp_q[0].size()), 64'd0);

    // Saturation on the 16-bit instance, then sticky ovf cleared by a new group.
    send(1, 8'hFF, 8'hFF, 2'b00, 1'b0);
    send(1, 8'hFF, 8'hFF, 2'b00, 1'b1);
    expect_result(1, "sat", 64'hFFFF, 1'b1, lat);
    send(1, 8'h02, 8'h03, 2'b00, 1'b1);
    expect_result(1, "after_sat", 64'd6, 1'b0, lat);

    // Reset with a held result and an open group.
    send(0, 8'h09, 8'h09, 2'b00, 1'b1);
    set_ready(0, 1'b0);
    send(0, 8'h01, 8'h01, 2'b00, 1'b0);
    tick(2);
    check("pre_rst_valid", 64'(bus0.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(bus0.in_ready), 64'd1);
    check("mid_rst_valid", 64'(bus0.out_valid), 64'd0);
    check("mid_rst_acc", 64'(bus0.out_acc), 64'd0);
    check("mid_rst_ovf", 64'(bus0.out_ovf), 64'd0);
    set_ready(0, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(1);
    send(0, 8'h05, 8'h07, 2'b00, 1'b1);
    expect_result(0, "post_rst", 64'd35, 1'b0, lat);

    tick(4);
    check("drain0", 64'(exp_q[0].size()), 64'd0);
    check("drain1", 64'(exp_q[1].size()), 64'd0);
    check("results0", 64'(n_results[0]), 64'd12);
    check("results1", 64'(n_results[1]), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
